// File: rtl/mc_pkg.sv
// Shared types and constants for the multi-cycle sequencer.
package mc_pkg;

  // Encoded sequencer state; values are visible on the state output.
  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StExec   = 3'd1,
    StMem    = 3'd2,
    StMuldiv = 3'd3,
    StHalted = 3'd4
  } state_t;

  // MIPS boot ROM address.
  localparam logic [31:0] DefaultResetVector = 32'hBFC0_0000;

endpackage

// File: rtl/mc_pc_unit.sv
// Program counter with MIPS branch-delay-slot redirection and halt detection.
module mc_pc_unit
  import mc_pkg::*;
#(
  parameter int unsigned     AddrW       = 32,
  parameter logic [AddrW-1:0] ResetVector = AddrW'(DefaultResetVector)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             commit_i,
  input  logic             redirect_i,
  input  logic [AddrW-1:0] redirect_target_i,
  output logic [AddrW-1:0] pc_o,
  output logic             halt_o
);

  logic [AddrW-1:0] pc_q, pc_d;
  logic             pending_q, pending_d;
  logic [AddrW-1:0] target_q, target_d;
  logic [AddrW-1:0] pc_next;

  // Sequential successor, or the deferred jump target once the delay slot retires.
  always_comb begin
    pc_next   = pending_q ? target_q : pc_q + AddrW'(4);
    pc_d      = pc_q;
    pending_d = pending_q;
    target_d  = target_q;
    if (commit_i) begin
      pc_d = pc_next;
      if (pending_q) begin
        // Retiring the delay slot; a branch sitting in it is dropped.
        pending_d = 1'b0;
      end else if (redirect_i) begin
        pending_d = 1'b1;
        target_d  = redirect_target_i;
      end
    end
  end

  // PC and delay-slot registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q      <= ResetVector;
      pending_q <= 1'b0;
      target_q  <= '0;
    end else begin
      pc_q      <= pc_d;
      pending_q <= pending_d;
      target_q  <= target_d;
    end
  end

  assign pc_o   = pc_q;
  assign halt_o = (pc_next == '0);

endmodule

// File: rtl/mc_sequencer.sv
// Multi-cycle FETCH/EXEC/MEM/MULDIV sequencer with waitrequest-tolerant memory handshakes.
module mc_sequencer
  import mc_pkg::*;
#(
  parameter int unsigned      ADDR_W        = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR  = ADDR_W'(DefaultResetVector),
  parameter int unsigned      MULDIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              instr_waitrequest,
  input  logic              data_waitrequest,
  input  logic              dec_load,
  input  logic              dec_store,
  input  logic              dec_muldiv,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              instr_read,
  output logic [ADDR_W-1:0] instr_address,
  output logic              ir_load,
  output logic              data_read,
  output logic              data_write,
  output logic              commit,
  output logic              muldiv_busy,
  output logic [2:0]        state,
  output logic              active,
  output logic              finish
);

  localparam int unsigned CntW = (MULDIV_CYCLES > 1) ? $clog2(MULDIV_CYCLES) : 1;

  state_t            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              redir_q, redir_d;
  logic [ADDR_W-1:0] redir_tgt_q, redir_tgt_d;
  logic              mem_load_q, mem_load_d;

  logic              commit_now;
  logic              redir_eff;
  logic [ADDR_W-1:0] redir_tgt_eff;
  logic              pc_halt;
  logic [ADDR_W-1:0] pc;

  logic instr_read_c, ir_load_c, data_read_c, data_write_c, muldiv_busy_c;

  // ALU ops commit in EXEC itself, so the live decode is used there instead of the capture.
  always_comb begin
    redir_eff     = (state_q == StExec) ? redirect_valid  : redir_q;
    redir_tgt_eff = (state_q == StExec) ? redirect_target : redir_tgt_q;
  end

  mc_pc_unit #(
    .AddrW       (ADDR_W),
    .ResetVector (RESET_VECTOR)
  ) u_pc_unit (
    .clk_i             (clk),
    .rst_ni            (reset),
    .commit_i          (commit_now),
    .redirect_i        (redir_eff),
    .redirect_target_i (redir_tgt_eff),
    .pc_o              (pc),
    .halt_o            (pc_halt)
  );

  // Next-state and decoded outputs.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    redir_d       = redir_q;
    redir_tgt_d   = redir_tgt_q;
    mem_load_d    = mem_load_q;
    commit_now    = 1'b0;
    instr_read_c  = 1'b0;
    ir_load_c     = 1'b0;
    data_read_c   = 1'b0;
    data_write_c  = 1'b0;
    muldiv_busy_c = 1'b0;

    unique case (state_q)
      StFetch: begin
        instr_read_c = 1'b1;
        if (!instr_waitrequest) begin
          ir_load_c = 1'b1;
          state_d   = StExec;
        end
      end
      StExec: begin
        redir_d     = redirect_valid;
        redir_tgt_d = redirect_target;
        if (dec_load || dec_store) begin
          // Load wins if both are (illegally) set.
          mem_load_d = dec_load;
          state_d    = StMem;
        end else if (dec_muldiv) begin
          cnt_d   = CntW'(MULDIV_CYCLES - 1);
          state_d = StMuldiv;
        end else begin
          commit_now = 1'b1;
        end
      end
      StMem: begin
        data_read_c  = mem_load_q;
        data_write_c = !mem_load_q;
        if (!data_waitrequest) begin
          commit_now = 1'b1;
        end
      end
      StMuldiv: begin
        muldiv_busy_c = 1'b1;
        if (cnt_q == '0) begin
          commit_now = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StHalted: begin
        state_d = StHalted;
      end
      default: begin
        state_d = StFetch;
      end
    endcase

    if (commit_now) begin
      state_d = pc_halt ? StHalted : StFetch;
    end
  end

  // FSM, MULDIV counter and captured decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StFetch;
      cnt_q       <= '0;
      redir_q     <= 1'b0;
      redir_tgt_q <= '0;
      mem_load_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      redir_q     <= redir_d;
      redir_tgt_q <= redir_tgt_d;
      mem_load_q  <= mem_load_d;
    end
  end

  // Requests and pulses are forced low while reset is held.
  always_comb begin
    instr_read    = instr_read_c  & reset;
    ir_load       = ir_load_c     & reset;
    data_read     = data_read_c   & reset;
    data_write    = data_write_c  & reset;
    commit        = commit_now    & reset;
    muldiv_busy   = muldiv_busy_c & reset;
    instr_address = pc;
    state         = state_q;
    active        = (state_q != StHalted);
    finish        = (state_q == StHalted);
  end

endmodule

// File: tb/tb_mc_sequencer.sv
// Directed self-checking bench for mc_sequencer (MULDIV_CYCLES = 4).
module tb_mc_sequencer;

  localparam int unsigned Mdc = 4;

  logic        clk;
  logic        reset;
  logic        instr_waitrequest;
  logic        data_waitrequest;
  logic        dec_load;
  logic        dec_store;
  logic        dec_muldiv;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_read;
  logic [31:0] instr_address;
  logic        ir_load;
  logic        data_read;
  logic        data_write;
  logic        commit;
  logic        muldiv_busy;
  logic [2:0]  state;
  logic        active;
  logic        finish;

  int n_chk = 0;
  int n_err = 0;

  mc_sequencer #(
    .ADDR_W        (32),
    .RESET_VECTOR  (32'hBFC0_0000),
    .MULDIV_CYCLES (Mdc)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .instr_waitrequest (instr_waitrequest),
    .data_waitrequest  (data_waitrequest),
    .dec_load          (dec_load),
    .dec_store         (dec_store),
    .dec_muldiv        (dec_muldiv),
    .redirect_valid    (redirect_valid),
    .redirect_target   (redirect_target),
    .instr_read        (instr_read),
    .instr_address     (instr_address),
    .ir_load           (ir_load),
    .data_read         (data_read),
    .data_write        (data_write),
    .commit            (commit),
    .muldiv_busy       (muldiv_busy),
    .state             (state),
    .active            (active),
    .finish            (finish)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic clear_decode();
    dec_load        = 1'b0;
    dec_store       = 1'b0;
    dec_muldiv      = 1'b0;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
  endtask

  // kind: 0 ALU, 1 load, 2 store, 3 mul/div. Entered at a falling edge with the DUT in FETCH.
  task automatic do_instr(input string name, input int kind, input int fw, input int dw,
                          input logic rv, input logic [31:0] tgt, input logic [31:0] exp_pc);
    int cyc;
    int exp_cyc;
    cyc = 0;
    clear_decode();
    data_waitrequest = 1'b0;
    for (int i = 0; i <= fw; i++) begin
      instr_waitrequest = (i < fw);
      #1;
      check({name, ".f_state"}, 32'(state), 32'd0);
      check({name, ".f_addr"}, instr_address, exp_pc);
      check({name, ".f_read"}, 32'(instr_read), 32'd1);
      check({name, ".f_irload"}, 32'(ir_load), 32'(i == fw));
      check({name, ".f_commit"}, 32'(commit), 32'd0);
      @(negedge clk);
      cyc++;
    end
    instr_waitrequest = 1'b1;
    dec_load        = (kind == 1);
    dec_store       = (kind == 2);
    dec_muldiv      = (kind == 3);
    redirect_valid  = rv;
    redirect_target = tgt;
    #1;
    check({name, ".e_state"}, 32'(state), 32'd1);
    check({name, ".e_commit"}, 32'(commit), 32'(kind == 0));
    check({name, ".e_irload"}, 32'(ir_load), 32'd0);
    check({name, ".e_read"}, 32'(instr_read), 32'd0);
    @(negedge clk);
    cyc++;
    if (kind == 1 || kind == 2) begin
      for (int i = 0; i <= dw; i++) begin
        data_waitrequest = (i < dw);
        #1;
        check({name, ".m_state"}, 32'(state), 32'd2);
        check({name, ".m_dread"}, 32'(data_read), 32'(kind == 1));
        check({name, ".m_dwrite"}, 32'(data_write), 32'(kind == 2));
        check({name, ".m_commit"}, 32'(commit), 32'(i == dw));
        @(negedge clk);
        cyc++;
      end
      data_waitrequest = 1'b0;
    end else if (kind == 3) begin
      for (int i = 0; i < int'(Mdc); i++) begin
        #1;
        check({name, ".md_state"}, 32'(state), 32'd3);
        check({name, ".md_busy"}, 32'(muldiv_busy), 32'd1);
        check({name, ".md_commit"}, 32'(commit), 32'(i == int'(Mdc) - 1));
        @(negedge clk);
        cyc++;
      end
    end
    clear_decode();
    exp_cyc = fw + 2 + ((kind == 1 || kind == 2) ? dw + 1 : 0) + ((kind == 3) ? int'(Mdc) : 0);
    check({name, ".cycles"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    reset             = 1'b0;
    instr_waitrequest = 1'b0;
    data_waitrequest  = 1'b0;
    clear_decode();

    // Reset state, with memory reporting ready so a leaking fetch pulse would show.
    #12;
    check("rst.state", 32'(state), 32'd0);
    check("rst.addr", instr_address, 32'hBFC0_0000);
    check("rst.instr_read", 32'(instr_read), 32'd0);
    check("rst.ir_load", 32'(ir_load), 32'd0);
    check("rst.commit", 32'(commit), 32'd0);
    check("rst.active", 32'(active), 32'd1);
    check("rst.finish", 32'(finish), 32'd0);

    @(negedge clk);
    reset = 1'b1;

    do_instr("alu0", 0, 0, 0, 1'b0, 32'h0, 32'hBFC0_0000);
    do_instr("alu1", 0, 0, 0, 1'b0, 32'h0, 32'hBFC0_0004);
    do_instr("alu2", 0, 0, 0, 1'b0, 32'h0, 32'hBFC0_0008);
    do_instr("fwait", 0, 3, 0, 1'b0, 32'h0, 32'hBFC0_000C);
    do_instr("jump", 0, 0, 0, 1'b1, 32'h0000_0100, 32'hBFC0_0010);
    // Delay-slot load carrying a branch that must be ignored.
    do_instr("dsload", 1, 0, 2, 1'b1, 32'h0000_0200, 32'hBFC0_0014);
    do_instr("mult", 3, 0, 0, 1'b0, 32'h0, 32'h0000_0100);
    do_instr("store", 2, 0, 0, 1'b0, 32'h0, 32'h0000_0104);
    do_instr("jr0", 0, 0, 0, 1'b1, 32'h0, 32'h0000_0108);
    do_instr("jrslot", 0, 0, 0, 1'b0, 32'h0, 32'h0000_010C);

    instr_waitrequest = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("halt.state", 32'(state), 32'd4);
      check("halt.finish", 32'(finish), 32'd1);
      check("halt.active", 32'(active), 32'd0);
      check("halt.instr_read", 32'(instr_read), 32'd0);
      check("halt.addr", instr_address, 32'h0);
      check("halt.commit", 32'(commit), 32'd0);
      @(negedge clk);
    end

    // Leave HALTED via reset, then abort a mul/div midway.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    instr_waitrequest = 1'b0;
    #1;
    check("re.addr", instr_address, 32'hBFC0_0000);
    @(negedge clk);
    dec_muldiv = 1'b1;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("abort.pre_state", 32'(state), 32'd3);
    check("abort.pre_busy", 32'(muldiv_busy), 32'd1);
    #1;
    reset = 1'b0;
    #1;
    check("abort.state", 32'(state), 32'd0);
    check("abort.addr", instr_address, 32'hBFC0_0000);
    check("abort.commit", 32'(commit), 32'd0);
    check("abort.busy", 32'(muldiv_busy), 32'd0);
    check("abort.active", 32'(active), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    do_instr("post0", 0, 0, 0, 1'b0, 32'h0, 32'hBFC0_0000);
    do_instr("post1", 0, 0, 0, 1'b0, 32'h0, 32'hBFC0_0004);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
